// File: rtl/pci_storage_bank.sv
// pci_storage_bank
//   DEPTH x 32-bit word store behind the PCI target storage controller.
//   Writes are posted into a BUF_DEPTH-entry FIFO and committed to the array
//   one entry every DRAIN_CYCLES clocks, merged byte-by-byte (BE is active-low).
//   Reads are only accepted once the FIFO is empty, so a read never returns a
//   word that still has a posted write pending.
// Ports
//   clock, reset        : system clock, async active-high reset
//   CMD                 : 0=READ 1=WRITE 2=DETERM 3..7=NOP
//   storage_address     : word address (used directly, or as burst start)
//   BE                  : active-low byte enables for writes
//   BURST_MODE          : 1 = internal auto-incrementing address
//   Sdata               : write data
//   Rdata               : registered read data (latency 1)
//   S_FULL              : stall request (FIFO full, or READ while FIFO busy)
//   B_FULL              : disconnect request after an access to the last word
//   buf_count           : FIFO occupancy (debug)

module pci_sb_byte_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       be_n,
  output logic [7:0] merged
);
  assign merged = be_n ? old_byte : new_byte;
endmodule

module pci_storage_bank #(
  parameter int DEPTH        = 8,
  parameter int BUF_DEPTH    = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  CMD,
  input  logic [2:0]  storage_address,
  input  logic [3:0]  BE,
  input  logic        BURST_MODE,
  input  logic [31:0] Sdata,
  output logic [31:0] Rdata,
  output logic        S_FULL,
  output logic        B_FULL,
  output logic [2:0]  buf_count
);
  localparam int NUM_LANES = 4;
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int TW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [2:0]    CMD_READ  = 3'd0;
  localparam logic [2:0]    CMD_WRITE = 3'd1;
  localparam logic [2:0]    CMD_DETERM = 3'd2;
  localparam logic [2:0]    BUF_FULL  = 3'(BUF_DEPTH);
  localparam logic [2:0]    LAST_ADDR = 3'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(BUF_DEPTH - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(DRAIN_CYCLES - 1);

  typedef struct packed {
    logic [2:0]  addr;
    logic [3:0]  be_n;
    logic [31:0] data;
  } wr_ent_t;

  wr_ent_t [BUF_DEPTH-1:0]   fifo_q, fifo_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]                count_q, count_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [DEPTH-1:0][31:0]    mem_q, mem_d;
  logic [2:0]                ptr_q, ptr_d;
  logic                      first_q, first_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      bfull_q, bfull_d;

  logic                      is_rw, is_nop, wr_acc, rd_acc, acc, pop;
  logic [2:0]                eff_addr;
  wr_ent_t                   head;
  logic [NUM_LANES-1:0][7:0] merged_word;

  assign head = fifo_q[rd_ptr_q];

  // Commit merge of the FIFO head into its target word, one instance per byte.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pci_sb_byte_lane u_lane (
      .old_byte (mem_q[head.addr][8*i +: 8]),
      .new_byte (head.data[8*i +: 8]),
      .be_n     (head.be_n[i]),
      .merged   (merged_word[i])
    );
  end

  always_comb begin
    is_rw    = (CMD == CMD_READ) || (CMD == CMD_WRITE);
    is_nop   = (CMD > CMD_DETERM);
    // first_q marks "no READ/WRITE since the last NOP": the burst start
    // comes straight from the address bus, later beats from the pointer.
    eff_addr = (BURST_MODE && !first_q) ? ptr_q : storage_address;
    wr_acc   = (CMD == CMD_WRITE) && (count_q != BUF_FULL);
    rd_acc   = (CMD == CMD_READ) && (count_q == 3'd0);
    acc      = wr_acc || rd_acc;
    pop      = (count_q != 3'd0) && (timer_q == T_LAST);
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    timer_d  = timer_q;
    mem_d    = mem_q;
    ptr_d    = ptr_q;
    first_d  = first_q;
    rdata_d  = rdata_q;
    bfull_d  = bfull_q;

    if (wr_acc) begin
      fifo_d[wr_ptr_q] = wr_ent_t'{addr: eff_addr, be_n: BE, data: Sdata};
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      mem_d[head.addr] = merged_word;
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Timer only runs while something is waiting to drain.
    if ((count_q == 3'd0) || pop) timer_d = '0;
    else                          timer_d = timer_q + 1'b1;

    // No commit can coincide with an accepted read (read needs empty FIFO).
    if (rd_acc) rdata_d = mem_q[eff_addr];

    // A blocked burst beat still latches its address so the retry hits it.
    if (BURST_MODE && is_rw)
      ptr_d = acc ? ((eff_addr == LAST_ADDR) ? 3'd0 : eff_addr + 3'd1) : eff_addr;

    if (is_nop)     first_d = 1'b1;
    else if (is_rw) first_d = 1'b0;

    if (acc && (eff_addr == LAST_ADDR)) bfull_d = 1'b1;
    else if (is_nop)                    bfull_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      mem_q    <= '0;
      ptr_q    <= '0;
      first_q  <= 1'b1;
      rdata_q  <= '0;
      bfull_q  <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      mem_q    <= mem_d;
      ptr_q    <= ptr_d;
      first_q  <= first_d;
      rdata_q  <= rdata_d;
      bfull_q  <= bfull_d;
    end
  end

  assign S_FULL    = (count_q == BUF_FULL) || ((CMD == CMD_READ) && (count_q != 3'd0));
  assign Rdata     = rdata_q;
  assign B_FULL    = bfull_q;
  assign buf_count = count_q;

endmodule
